// File: rtl/controller_v2.sv
// rtl/controller_v2.sv - multi-cycle CPU control FSM with wait-stated fetch, flag branches, trap, halt and retire counter
module controller_v2 #(
  parameter int OP_W      = 4,
  parameter int ALU_SEL_W = 4,
  parameter int WAIT_CYC  = 0,
  parameter int CNT_W     = 16
) (
  input  logic                 clk,
  input  logic                 CLB,
  input  logic [OP_W-1:0]      op,
  input  logic                 z,
  input  logic                 c,
  input  logic                 mem_rdy,
  input  logic                 run,
  output logic                 LoadIR,
  output logic                 IncPC,
  output logic                 SelPC,
  output logic                 LoadPC,
  output logic                 LoadReg,
  output logic                 LoadAcc,
  output logic [1:0]           SelAcc,
  output logic [ALU_SEL_W-1:0] SelALU,
  output logic                 halted,
  output logic                 trap,
  output logic [CNT_W-1:0]     instr_cnt
);

  typedef enum logic [2:0] {
    INIT, FETCH, DECODE, BRANCH, EXEC_ACC, EXEC_REG, HALT, TRAP
  } state_t;

  localparam logic [3:0] OP_NOP  = 4'b0000;
  localparam logic [3:0] OP_MOVR = 4'b0100;
  localparam logic [3:0] OP_MOVA = 4'b0101;
  localparam logic [3:0] OP_JZRS = 4'b0110;
  localparam logic [3:0] OP_JZIM = 4'b0111;
  localparam logic [3:0] OP_JCRS = 4'b1000;
  localparam logic [3:0] OP_JCIM = 4'b1010;
  localparam logic [3:0] OP_LDIM = 4'b1101;
  localparam logic [3:0] OP_HALT = 4'b1111;
  localparam logic [3:0] WAIT_MAX = 4'(WAIT_CYC);

  state_t     state;
  state_t     decode_next;
  logic [3:0] wait_cnt;
  logic [3:0] op_lo;
  logic       op_hi_zero;
  logic       fetch_ok;
  logic       is_jz;
  logic       is_jc;
  logic       retire;

  assign op_lo      = op[3:0];
  assign op_hi_zero = (op >> 4) == '0;
  assign fetch_ok   = (wait_cnt == WAIT_MAX) && mem_rdy;
  assign is_jz      = (op_lo == OP_JZRS) || (op_lo == OP_JZIM);
  assign is_jc      = (op_lo == OP_JCRS) || (op_lo == OP_JCIM);

  always_comb begin
    decode_next = TRAP;
    if (op_hi_zero) begin
      case (op_lo)
        OP_NOP:                            decode_next = FETCH;
        OP_HALT:                           decode_next = HALT;
        OP_MOVA:                           decode_next = EXEC_REG;
        OP_JZRS, OP_JZIM, OP_JCRS, OP_JCIM: decode_next = BRANCH;
        4'b1001, 4'b1110:                  decode_next = TRAP;
        default:                           decode_next = EXEC_ACC;
      endcase
    end
  end

  // NOP and HALT retire as they leave DECODE; everything else retires in its execute state.
  assign retire = ((state == DECODE) && ((decode_next == FETCH) || (decode_next == HALT)))
               || (state == BRANCH) || (state == EXEC_ACC) || (state == EXEC_REG);

  always_ff @(posedge clk) begin
    if (!CLB) begin
      state     <= INIT;
      wait_cnt  <= '0;
      instr_cnt <= '0;
    end else begin
      if (retire) instr_cnt <= instr_cnt + CNT_W'(1);
      case (state)
        INIT:   state <= FETCH;
        FETCH: begin
          if (fetch_ok) begin
            state    <= DECODE;
            wait_cnt <= '0;
          end else if (wait_cnt != WAIT_MAX) begin
            wait_cnt <= wait_cnt + 4'd1;
          end
        end
        DECODE:                      state <= decode_next;
        BRANCH, EXEC_ACC, EXEC_REG:  state <= FETCH;
        HALT:   if (run) state <= FETCH;
        TRAP:   state <= TRAP;
        default: state <= INIT;
      endcase
    end
  end

  always_comb begin
    LoadIR  = 1'b0;
    IncPC   = 1'b0;
    SelPC   = 1'b0;
    LoadPC  = 1'b0;
    LoadReg = 1'b0;
    LoadAcc = 1'b0;
    SelAcc  = 2'b00;
    SelALU  = '0;
    halted  = 1'b0;
    trap    = 1'b0;
    case (state)
      FETCH:  LoadIR = fetch_ok;
      DECODE: IncPC  = 1'b1;
      BRANCH: begin
        SelPC  = (op_lo == OP_JZRS) || (op_lo == OP_JCRS);
        LoadPC = (is_jz && z) || (is_jc && c);
      end
      EXEC_ACC: begin
        LoadAcc = 1'b1;
        SelAcc  = (op_lo == OP_MOVR) ? 2'b10 : (op_lo == OP_LDIM) ? 2'b11 : 2'b00;
        SelALU  = ALU_SEL_W'(op_lo);
      end
      EXEC_REG: LoadReg = 1'b1;
      HALT:     halted  = 1'b1;
      TRAP:     trap    = 1'b1;
      default:  ;
    endcase
  end

endmodule

// File: tb/tb_controller_v2.sv
// tb/tb_controller_v2.sv - directed bench for controller_v2 over three parameter sets
module tb_controller_v2;

  localparam logic [4:0] ADD  = 5'b00001;
  localparam logic [4:0] MOVR = 5'b00100;
  localparam logic [4:0] MOVA = 5'b00101;
  localparam logic [4:0] JZRS = 5'b00110;
  localparam logic [4:0] JCIM = 5'b01010;
  localparam logic [4:0] LDIM = 5'b01101;
  localparam logic [4:0] HLT  = 5'b01111;
  localparam logic [4:0] NOP  = 5'b00000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       CLB, z, c, mem_rdy, run;
  logic [4:0] op;

  logic LoadIR_a, IncPC_a, SelPC_a, LoadPC_a, LoadReg_a, LoadAcc_a, halted_a, trap_a;
  logic [1:0]  SelAcc_a;
  logic [3:0]  SelALU_a;
  logic [15:0] instr_cnt_a;
  logic LoadIR_b, IncPC_b, SelPC_b, LoadPC_b, LoadReg_b, LoadAcc_b, halted_b, trap_b;
  logic [1:0]  SelAcc_b;
  logic [3:0]  SelALU_b;
  logic [15:0] instr_cnt_b;
  logic LoadIR_c, IncPC_c, SelPC_c, LoadPC_c, LoadReg_c, LoadAcc_c, halted_c, trap_c;
  logic [1:0]  SelAcc_c;
  logic [3:0]  SelALU_c;
  logic [2:0]  instr_cnt_c;

  // {LoadIR,IncPC,SelPC,LoadPC,LoadReg,LoadAcc,SelAcc,SelALU}
  logic [11:0] o_a;
  assign o_a = {LoadIR_a, IncPC_a, SelPC_a, LoadPC_a, LoadReg_a, LoadAcc_a, SelAcc_a, SelALU_a};

  controller_v2 #(.OP_W(5), .ALU_SEL_W(4), .WAIT_CYC(0), .CNT_W(16)) dut_a (
    .clk(clk), .CLB(CLB), .op(op), .z(z), .c(c), .mem_rdy(mem_rdy), .run(run),
    .LoadIR(LoadIR_a), .IncPC(IncPC_a), .SelPC(SelPC_a), .LoadPC(LoadPC_a),
    .LoadReg(LoadReg_a), .LoadAcc(LoadAcc_a), .SelAcc(SelAcc_a), .SelALU(SelALU_a),
    .halted(halted_a), .trap(trap_a), .instr_cnt(instr_cnt_a));

  controller_v2 #(.OP_W(4), .ALU_SEL_W(4), .WAIT_CYC(2), .CNT_W(16)) dut_b (
    .clk(clk), .CLB(CLB), .op(op[3:0]), .z(z), .c(c), .mem_rdy(mem_rdy), .run(run),
    .LoadIR(LoadIR_b), .IncPC(IncPC_b), .SelPC(SelPC_b), .LoadPC(LoadPC_b),
    .LoadReg(LoadReg_b), .LoadAcc(LoadAcc_b), .SelAcc(SelAcc_b), .SelALU(SelALU_b),
    .halted(halted_b), .trap(trap_b), .instr_cnt(instr_cnt_b));

  controller_v2 #(.OP_W(4), .ALU_SEL_W(4), .WAIT_CYC(0), .CNT_W(3)) dut_c (
    .clk(clk), .CLB(CLB), .op(op[3:0]), .z(z), .c(c), .mem_rdy(mem_rdy), .run(run),
    .LoadIR(LoadIR_c), .IncPC(IncPC_c), .SelPC(SelPC_c), .LoadPC(LoadPC_c),
    .LoadReg(LoadReg_c), .LoadAcc(LoadAcc_c), .SelAcc(SelAcc_c), .SelALU(SelALU_c),
    .halted(halted_c), .trap(trap_c), .instr_cnt(instr_cnt_c));

  int checks = 0;
  int passes = 0;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    CLB = 1'b0;
    step();
    CLB = 1'b1;
  endtask

  task automatic test_reset();
    op = ADD; z = 1'b0; c = 1'b0; mem_rdy = 1'b1; run = 1'b0;
    do_reset();
    checks++; if (o_a !== 12'h000) $display("FAIL reset_strobes got %h exp %h", o_a, 12'h000); else passes++;
    checks++; if ({halted_a, trap_a} !== 2'b00) $display("FAIL reset_flags got %b exp 00", {halted_a, trap_a}); else passes++;
    checks++; if (instr_cnt_a !== 16'd0) $display("FAIL reset_cnt got %0d exp 0", instr_cnt_a); else passes++;
    checks++; if ({LoadIR_b, LoadIR_c, instr_cnt_c} !== 5'b0) $display("FAIL reset_others got %b exp 0", {LoadIR_b, LoadIR_c, instr_cnt_c}); else passes++;
  endtask

  task automatic test_add();
    step();
    checks++; if (o_a !== 12'h800) $display("FAIL add_fetch got %h exp %h", o_a, 12'h800); else passes++;
    step();
    checks++; if (o_a !== 12'h400) $display("FAIL add_decode got %h exp %h", o_a, 12'h400); else passes++;
    step();
    checks++; if (o_a !== 12'h041) $display("FAIL add_exec got %h exp %h", o_a, 12'h041); else passes++;
    step();
    checks++; if (instr_cnt_a !== 16'd1) $display("FAIL add_cnt got %0d exp 1", instr_cnt_a); else passes++;
    checks++; if (o_a !== 12'h800) $display("FAIL add_refetch got %h exp %h", o_a, 12'h800); else passes++;
  endtask

  task automatic test_wait();
    logic early;
    mem_rdy = 1'b1;
    do_reset();
    step();
    checks++; if (LoadIR_b !== 1'b0) $display("FAIL wait_c1 got %b exp 0", LoadIR_b); else passes++;
    step();
    checks++; if (LoadIR_b !== 1'b0) $display("FAIL wait_c2 got %b exp 0", LoadIR_b); else passes++;
    step();
    checks++; if (LoadIR_b !== 1'b1) $display("FAIL wait_c3 got %b exp 1", LoadIR_b); else passes++;
    mem_rdy = 1'b0;
    do_reset();
    step();
    early = 1'b0;
    for (int i = 0; i < 5; i++) begin
      if (LoadIR_b !== 1'b0) early = 1'b1;
      step();
    end
    checks++; if (early !== 1'b0) $display("FAIL wait_stall_early got %b exp 0", early); else passes++;
    mem_rdy = 1'b1;
    #1;
    checks++; if (LoadIR_b !== 1'b1) $display("FAIL wait_sixth got %b exp 1", LoadIR_b); else passes++;
    step();
    checks++; if (IncPC_b !== 1'b1) $display("FAIL wait_decode got %b exp 1", IncPC_b); else passes++;
  endtask

  task automatic test_branch();
    do_reset();
    step();
    op = JZRS; z = 1'b0; c = 1'b1;
    step(); step();
    checks++; if (o_a !== 12'h200) $display("FAIL jzrs_z0 got %h exp %h", o_a, 12'h200); else passes++;
    step();
    z = 1'b1;
    step(); step();
    checks++; if (o_a !== 12'h300) $display("FAIL jzrs_z1 got %h exp %h", o_a, 12'h300); else passes++;
    step();
    op = JCIM; z = 1'b0; c = 1'b1;
    step(); step();
    checks++; if (o_a !== 12'h100) $display("FAIL jcim_c1 got %h exp %h", o_a, 12'h100); else passes++;
    step();
    checks++; if (instr_cnt_a !== 16'd3) $display("FAIL branch_cnt got %0d exp 3", instr_cnt_a); else passes++;
    c = 1'b0;
  endtask

  task automatic test_acc_src();
    op = LDIM;
    step(); step();
    checks++; if (o_a !== 12'h07D) $display("FAIL ldim got %h exp %h", o_a, 12'h07D); else passes++;
    step();
    op = MOVR;
    step(); step();
    checks++; if (o_a !== 12'h064) $display("FAIL movr got %h exp %h", o_a, 12'h064); else passes++;
    step();
    op = MOVA;
    step(); step();
    checks++; if (o_a !== 12'h080) $display("FAIL mova got %h exp %h", o_a, 12'h080); else passes++;
    step();
  endtask

  task automatic test_trap();
    logic bad;
    op = 5'b01001;
    do_reset();
    step(); step(); step();
    checks++; if ({trap_a, o_a} !== 13'h1000) $display("FAIL trap_enter got %h exp %h", {trap_a, o_a}, 13'h1000); else passes++;
    bad = 1'b0;
    for (int i = 0; i < 20; i++) begin
      step();
      if ({trap_a, o_a} !== 13'h1000) bad = 1'b1;
    end
    checks++; if (bad !== 1'b0) $display("FAIL trap_hold got %b exp 0", bad); else passes++;
    checks++; if (instr_cnt_a !== 16'd0) $display("FAIL trap_cnt got %0d exp 0", instr_cnt_a); else passes++;
    do_reset();
    checks++; if (trap_a !== 1'b0) $display("FAIL trap_clear got %b exp 0", trap_a); else passes++;
    op = 5'b10001;
    step(); step(); step();
    checks++; if (trap_a !== 1'b1) $display("FAIL trap_upper got %b exp 1", trap_a); else passes++;
  endtask

  task automatic test_halt();
    op = HLT; run = 1'b0;
    do_reset();
    step(); step(); step();
    checks++; if (halted_a !== 1'b1) $display("FAIL halt_enter got %b exp 1", halted_a); else passes++;
    repeat (5) step();
    checks++; if ({halted_a, o_a} !== 13'h1000) $display("FAIL halt_hold got %h exp %h", {halted_a, o_a}, 13'h1000); else passes++;
    checks++; if (instr_cnt_a !== 16'd1) $display("FAIL halt_cnt got %0d exp 1", instr_cnt_a); else passes++;
    run = 1'b1;
    step();
    run = 1'b0;
    checks++; if ({halted_a, o_a} !== 13'h0800) $display("FAIL halt_resume got %h exp %h", {halted_a, o_a}, 13'h0800); else passes++;
    op = ADD;
    step(); step();
    checks++; if (o_a !== 12'h041) $display("FAIL abort_exec got %h exp %h", o_a, 12'h041); else passes++;
    CLB = 1'b0;
    step();
    checks++; if (o_a !== 12'h000) $display("FAIL abort_strobes got %h exp %h", o_a, 12'h000); else passes++;
    checks++; if (instr_cnt_a !== 16'd0) $display("FAIL abort_cnt got %0d exp 0", instr_cnt_a); else passes++;
    CLB = 1'b1;
    step();
    checks++; if (o_a !== 12'h800) $display("FAIL abort_refetch got %h exp %h", o_a, 12'h800); else passes++;
  endtask

  task automatic test_wrap();
    op = NOP;
    do_reset();
    step();
    step();
    checks++; if (IncPC_c !== 1'b1) $display("FAIL nop_decode got %b exp 1", IncPC_c); else passes++;
    step();
    checks++; if ({LoadIR_c, instr_cnt_c} !== 4'b1001) $display("FAIL nop_latency got %b exp 1001", {LoadIR_c, instr_cnt_c}); else passes++;
    for (int k = 1; k < 7; k++) begin
      step(); step();
    end
    checks++; if (instr_cnt_c !== 3'd7) $display("FAIL wrap_seven got %0d exp 7", instr_cnt_c); else passes++;
    step(); step();
    checks++; if (instr_cnt_c !== 3'd0) $display("FAIL wrap_zero got %0d exp 0", instr_cnt_c); else passes++;
  endtask

  initial begin
    CLB = 1'b0; op = NOP; z = 1'b0; c = 1'b0; mem_rdy = 1'b1; run = 1'b0;
    test_reset();
    test_add();
    test_wait();
    test_branch();
    test_acc_src();
    test_trap();
    test_halt();
    test_wrap();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
